// File: rtl/apb_master_bridge_pkg.sv
// Shared types and defaults for the APB master bridge.
// The optional ACCESS-phase timeout is built only when APB_TIMEOUT_EN is defined.
package apb_pkg;

  localparam int APB_ADDR_W_DEF = 32;
  localparam int APB_DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                      write;
    logic [APB_ADDR_W_DEF-1:0] addr;
    logic [APB_DATA_W_DEF-1:0] wdata;
  } apb_cmd_t;

  typedef struct packed {
    logic                      write;
    logic [APB_DATA_W_DEF-1:0] rdata;
    logic                      err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command stream, response stream and APB bus of the bridge.
// master = bridge side, slave = command source / response sink / APB completer.
interface apb_master_bridge_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W_DEF,
  parameter int DATA_W = APB_DATA_W_DEF
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_write;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_master_bridge_rsp_buf.sv
// Single-entry response holding register with valid/ready drain.
// A load in the same cycle as a drain refills the entry (load wins).
module apb_rsp_buf #(
  parameter int DATA_W = 32
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              err_i,
  input  logic              write_i,
  input  logic              drain_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              write_o
);

  logic              valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              write_q;

  // Fill on load, empty on drain; fields stay put while the entry is held.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      write_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      rdata_q <= rdata_i;
      err_q   <= err_i;
      write_q <= write_i;
    end else if (drain_i && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign write_o = write_q;

endmodule

// File: rtl/apb_master_bridge.sv
// APB master bridge: valid/ready commands in, one APB transfer at a time,
// completion captured into a one-entry response buffer.
// Optional macro APB_TIMEOUT_EN: abort ACCESS after TIMEOUT_CYCLES wait cycles.
//
// state  | meaning
// IDLE   | bus quiet; accepts a command when the response buffer is free
// SETUP  | psel=1, penable=0 for exactly one cycle
// ACCESS | psel=1, penable=1; waits for pready (or timeout when enabled)
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W_DEF,
  parameter int DATA_W         = APB_DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                pclk,
  input logic                prst,
  apb_master_bridge_if.master bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be 1..255");
  end

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              ready_q, ready_d;

  logic              rsp_valid;
  logic              cmd_ready;
  logic              cmd_fire;
  logic              rsp_load;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              rsp_err_d;

`ifdef APB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt_q, wait_cnt_d;
`endif

  // ready_q is the registered "in IDLE" qualifier; the buffer term lets a
  // drain and a new accept share one cycle.
  assign cmd_ready = ready_q & (~rsp_valid | bus.rsp_ready);
  assign cmd_fire  = bus.cmd_valid & cmd_ready;

  // State and APB drive registers.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      ready_q   <= ready_d;
    end
  end

`ifdef APB_TIMEOUT_EN
  // ACCESS-phase wait counter.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) wait_cnt_q <= '0;
    else      wait_cnt_q <= wait_cnt_d;
  end
`endif

  // Next-state, APB drive and response-capture decode.
  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pwrite_d    = pwrite_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    rsp_load    = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          paddr_d  = bus.cmd_addr;
          pwrite_d = bus.cmd_write;
          // reads keep the last written data on pwdata
          if (bus.cmd_write) pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d  = 1'b1;
        state_d    = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (bus.pready) begin
          rsp_load    = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  apb_rsp_buf #(.DATA_W(DATA_W)) u_rsp_buf (
    .pclk    (pclk),
    .prst    (prst),
    .load_i  (rsp_load),
    .rdata_i (rsp_rdata_d),
    .err_i   (rsp_err_d),
    .write_i (pwrite_q),
    .drain_i (bus.rsp_ready),
    .valid_o (rsp_valid),
    .rdata_o (bus.rsp_rdata),
    .err_o   (bus.rsp_err),
    .write_o (bus.rsp_write)
  );

  assign bus.rsp_valid = rsp_valid;
  assign bus.cmd_ready = cmd_ready;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a small APB slave memory whose
// pready is registered (earliest in the second ACCESS cycle).
// Build with APB_TIMEOUT_EN defined to exercise the timeout path.
module tb_apb_master_bridge;
  import apb_pkg::*;

  logic pclk;
  logic prst;

  apb_master_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .pclk (pclk),
    .prst (prst),
    .bus  (bus)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rsp_hs   = 0;
  int rsp_errs = 0;

  // slave model controls
  int   low_cycles = 1;
  bit   err_en     = 1'b0;
  bit   stuck      = 1'b0;
  int   acc_cnt;
  logic [31:0] mem [0:15];

  always @(posedge pclk) cyc <= cyc + 1;

  always @(posedge pclk) begin
    if (!prst && bus.rsp_valid && bus.rsp_ready) begin
      rsp_hs <= rsp_hs + 1;
      if (bus.rsp_err) rsp_errs <= rsp_errs + 1;
    end
  end

  always @(posedge pclk or posedge prst) begin
    if (prst) begin
      bus.pready <= 1'b0;
      acc_cnt    <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (bus.psel && bus.penable && !bus.pready) begin
        acc_cnt    <= acc_cnt + 1;
        bus.pready <= !stuck && (acc_cnt + 1 >= low_cycles);
      end else begin
        acc_cnt    <= 0;
        bus.pready <= 1'b0;
      end
      if (bus.psel && bus.penable && bus.pready && bus.pwrite)
        mem[bus.paddr[3:0]] <= bus.pwdata;
    end
  end

  assign bus.prdata  = mem[bus.paddr[3:0]];
  assign bus.pslverr = err_en & bus.pready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Present a command and return one cycle after its handshake edge.
  task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d);
    int n;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.cmd_ready) check("cmd_accept", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input bit drain, output logic [31:0] rd, output bit er,
                      output bit rw, output int psel_n, output int pen_n,
                      output int lat, output bit stable);
    send_cmd(wr, a, d);
    psel_n = 0;
    pen_n  = 0;
    lat    = 1;
    stable = 1'b1;
    while (!bus.rsp_valid && lat < 60) begin
      if (bus.psel) psel_n++;
      if (bus.penable) pen_n++;
      if (bus.psel && (bus.paddr !== a || bus.pwrite !== wr)) stable = 1'b0;
      tick();
      lat++;
    end
    check("rsp_seen", bus.rsp_valid, 1);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    rw = bus.rsp_write;
    if (drain) begin
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
    end
  endtask

  logic [31:0] rd;
  bit          er, rw, stable, cr_seen;
  int          psel_n, pen_n, lat, n, acc_n, hs0, err0;
  int          acc_cyc [4];
  apb_cmd_t    b2b [4];

  initial begin
    prst          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_write, bus.rsp_rdata}, 0);
    check("rst_apb_addr_data", {bus.pwrite, bus.paddr, bus.pwdata}, 0);
    prst = 1'b0;
    tick();

    // reset while a write of 0x3 sits in ACCESS
    send_cmd(1'b1, 32'h3, 32'hAAAA_5555);
    tick();
    check("midacc_penable", {bus.psel, bus.penable}, 2'b11);
    #2 prst = 1'b1;
    #1;
    check("midacc_rst_apb", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, 0);
    check("midacc_rst_hs", {bus.cmd_ready, bus.rsp_valid}, 0);
    tick();
    prst = 1'b0;
    tick();

    // write 0x2 then read it back
    xfer(1'b1, 32'h2, 32'hDEAD_BEEF, 1'b1, rd, er, rw, psel_n, pen_n, lat, stable);
    check("wr_rsp", {rw, er, rd}, {1'b1, 1'b0, 32'h0});
    check("wr_psel_cycles", psel_n, 3);
    check("wr_penable_cycles", pen_n, 2);
    check("wr_latency", lat, 4);
    xfer(1'b0, 32'h2, 32'h0, 1'b1, rd, er, rw, psel_n, pen_n, lat, stable);
    check("rd_rsp", {rw, er, rd}, {1'b0, 1'b0, 32'hDEAD_BEEF});
    check("rd_psel_penable", {psel_n[3:0], pen_n[3:0]}, {4'd3, 4'd2});
    check("rd_pwdata_held", bus.pwdata, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h3, 32'h0, 1'b1, rd, er, rw, psel_n, pen_n, lat, stable);
    check("rd_aborted_addr3", rd, 32'h0);

    // response backpressure on a read of 0x5
    xfer(1'b1, 32'h5, 32'h1234_5678, 1'b1, rd, er, rw, psel_n, pen_n, lat, stable);
    xfer(1'b0, 32'h5, 32'h0, 1'b0, rd, er, rw, psel_n, pen_n, lat, stable);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 32'h6;
    bus.cmd_wdata = 32'h66;
    stable  = 1'b1;
    cr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_ready) cr_seen = 1'b1;
      if (!bus.rsp_valid || bus.rsp_rdata !== 32'h1234_5678 || bus.rsp_err || bus.rsp_write)
        stable = 1'b0;
      tick();
    end
    check("bp_rsp_stable", stable, 1);
    check("bp_cmd_ready_low", cr_seen, 0);
    check("bp_psel_idle", bus.psel, 0);
    bus.rsp_ready = 1'b1;
    #1;
    check("bp_drain_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("bp_drained", bus.rsp_valid, 0);
    check("bp_accepted", {bus.psel, bus.penable, bus.paddr}, {1'b1, 1'b0, 32'h6});
    n = 0;
    while (!bus.rsp_valid && n < 50) begin tick(); n++; end
    check("bp_second_rsp", {bus.rsp_valid, bus.rsp_write}, 2'b11);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;

    // wait states with slave error on read of 0x7
    low_cycles = 5;
    err_en     = 1'b1;
    xfer(1'b0, 32'h7, 32'h0, 1'b1, rd, er, rw, psel_n, pen_n, lat, stable);
    check("ws_access_cycles", pen_n, 6);
    check("ws_addr_stable", stable, 1);
    check("ws_err", {rw, er}, 2'b01);
    check("ws_back_idle", {bus.psel, bus.penable, bus.cmd_ready}, 3'b001);
    low_cycles = 1;
    err_en     = 1'b0;

    // back-to-back writes with rsp_ready tied high
    for (int i = 0; i < 4; i++) begin
      b2b[i].write = 1'b1;
      b2b[i].addr  = 32'(i);
      b2b[i].wdata = 32'h10 + 32'(i);
    end
    hs0  = rsp_hs;
    err0 = rsp_errs;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = b2b[i].write;
      bus.cmd_addr  = b2b[i].addr;
      bus.cmd_wdata = b2b[i].wdata;
      n = 0;
      while (!bus.cmd_ready && n < 50) begin tick(); n++; end
      acc_cyc[i] = cyc;
      tick();
    end
    bus.cmd_valid = 1'b0;
    repeat (6) tick();
    bus.rsp_ready = 1'b0;
    for (int i = 1; i < 4; i++) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 4);
    check("b2b_rsp_count", rsp_hs - hs0, 4);
    check("b2b_rsp_errs", rsp_errs - err0, 0);
    for (int i = 0; i < 4; i++) begin
      xfer(1'b0, 32'(i), 32'h0, 1'b1, rd, er, rw, psel_n, pen_n, lat, stable);
      check("b2b_readback", rd, 32'h10 + 32'(i));
    end

    // slave never answers
    stuck = 1'b1;
`ifdef APB_TIMEOUT_EN
    send_cmd(1'b0, 32'h9, 32'h0);
    acc_n = 0;
    n     = 0;
    while (!bus.rsp_valid && n < 200) begin
      if (bus.penable) acc_n++;
      tick();
      n++;
    end
    check("to_access_cycles", acc_n, 16);
    check("to_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}, {2'b11, 32'h0});
    check("to_idle", {bus.psel, bus.penable}, 2'b00);
`else
    send_cmd(1'b0, 32'h9, 32'h0);
    repeat (100) tick();
    check("nto_still_access", {bus.psel, bus.penable, bus.rsp_valid}, 3'b110);
`endif
    stuck = 1'b0;
    prst  = 1'b1;
    tick();
    prst  = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
